// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end.
// Owns the fetch PC and issues word requests to instruction memory over a
// valid/ready request channel with in-order responses. Returned words are
// buffered with their PC in a small FIFO and offered to decode over
// valid/ready. A redirect (taken branch/jump) reloads the PC, flushes the
// FIFO and discards every response still in flight.
//
// Ports
//   clk_in             clock, rising edge
//   reset              asynchronous, active-low reset
//   imem_req_valid_out fetch request valid
//   imem_req_ready_in  memory accepts request
//   imem_req_addr_out  fetch address, word aligned
//   imem_resp_valid_in response valid (in order)
//   imem_resp_data_in  instruction word
//   inst_valid_out     FIFO head valid to decode
//   inst_ready_in      decode consumes head
//   inst_out           head instruction, 0 when empty
//   inst_pc_out        head PC, 0 when empty
//   redirect_in        redirect fetch
//   redirect_pc_in     new fetch PC, bits [1:0] ignored
module inst_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            FIFO_DEPTH = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    output logic                  imem_req_valid_out,
    input  logic                  imem_req_ready_in,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_out,
    input  logic                  imem_resp_valid_in,
    input  logic [31:0]           imem_resp_data_in,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc_out,
    input  logic                  redirect_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {StBoot, StFetch, StFlush} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    cnt_t                  fifo_cnt_q, fifo_cnt_d;
    cnt_t                  outstanding_q, outstanding_d;
    cnt_t                  drop_cnt_q, drop_cnt_d;
    ptr_t                  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    ptr_t                  pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pcq       [FIFO_DEPTH];  // PCs of requests awaiting response

    logic        redir, pop, resp, drop, push, req_valid, accept;
    logic [CW:0] credit;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign redir = redirect_in && (state_q != StBoot);
    assign pop   = (fifo_cnt_q != '0) && inst_ready_in;
    assign resp  = imem_resp_valid_in && (outstanding_q != '0);
    assign drop  = resp && (drop_cnt_q != '0);
    // A response in the redirect cycle belongs to the old stream: discard it.
    assign push  = resp && !drop && !redir;

    // Credits count the slot freed by this cycle's pop, so that a 1-cycle
    // memory can sustain one instruction per cycle with a 2-entry FIFO.
    assign credit    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop};
    assign req_valid = (state_q == StFetch) && !redirect_in && (credit < DEPTH_C);
    assign accept    = req_valid && imem_req_ready_in;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        fifo_cnt_d    = fifo_cnt_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        pcq_rd_d      = resp ? ptr_inc(pcq_rd_q) : pcq_rd_q;
        pcq_wr_d      = accept ? ptr_inc(pcq_wr_q) : pcq_wr_q;
        outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(resp);
        drop_cnt_d    = drop ? drop_cnt_q - cnt_t'(1) : drop_cnt_q;

        if (redir) begin
            fetch_pc_d = {redirect_pc_in[ADDR_WIDTH-1:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            // Everything still outstanding after this cycle is stale.
            drop_cnt_d = outstanding_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (push) begin
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
            fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end

        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: if (redir && (outstanding_d != '0)) state_d = StFlush;
            StFlush: if (!redir && (drop_cnt_d == '0)) state_d = StFetch;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= StBoot;
            fetch_pc_q    <= RESET_PC;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            pcq_wr_q      <= pcq_wr_d;
        end
    end

    // Storage needs no reset; validity is tracked by the counters above.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_data[fifo_wr_q] <= imem_resp_data_in;
            fifo_pc[fifo_wr_q]   <= pcq[pcq_rd_q];
        end
        if (accept) begin
            pcq[pcq_wr_q] <= fetch_pc_q;
        end
    end

    assign imem_req_valid_out = req_valid;
    assign imem_req_addr_out  = fetch_pc_q;
    assign inst_valid_out     = (fifo_cnt_q != '0);
    assign inst_out           = inst_valid_out ? fifo_data[fifo_rd_q] : '0;
    assign inst_pc_out        = inst_valid_out ? fifo_pc[fifo_rd_q] : '0;

    resp_without_request_a: assert property (
        @(posedge clk_in) disable iff (!reset) imem_resp_valid_in |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req_ready = 1'b1;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        inst_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid, inst_valid;
    logic [31:0] req_addr, inst, inst_pc;

    logic        w_req_valid, w_inst_valid, w_resp_valid;
    logic [31:0] w_req_addr, w_inst, w_inst_pc;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk_in(clk), .reset(rst_n),
        .imem_req_valid_out(req_valid), .imem_req_ready_in(req_ready),
        .imem_req_addr_out(req_addr),
        .imem_resp_valid_in(resp_valid), .imem_resp_data_in(resp_data),
        .inst_valid_out(inst_valid), .inst_ready_in(inst_ready),
        .inst_out(inst), .inst_pc_out(inst_pc),
        .redirect_in(redirect), .redirect_pc_in(redirect_pc)
    );

    // Second instance only exercises the top-of-address-space reset PC.
    inst_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk_in(clk), .reset(rst_n),
        .imem_req_valid_out(w_req_valid), .imem_req_ready_in(1'b1),
        .imem_req_addr_out(w_req_addr),
        .imem_resp_valid_in(w_resp_valid), .imem_resp_data_in(32'h1234_0000),
        .inst_valid_out(w_inst_valid), .inst_ready_in(1'b1),
        .inst_out(w_inst), .inst_pc_out(w_inst_pc),
        .redirect_in(1'b0), .redirect_pc_in(32'h0)
    );

    // Memory model: in-order, response mem_lat cycles after accept, data = ~addr.
    int          cyc = 0;
    int          mem_lat = 1;
    logic [31:0] mq_addr[$];
    int          mq_cyc[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    logic [31:0] wlog[$];
    bit          w_acc = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_addr.delete(); mq_cyc.delete(); acc_log.delete();
            del_pc.delete(); del_inst.delete(); wlog.delete();
            w_acc = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (resp_valid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_cyc.pop_front());
            end
            if (req_valid && req_ready) begin
                mq_addr.push_back(req_addr);
                mq_cyc.push_back(cyc);
                acc_log.push_back(req_addr);
            end
            if (inst_valid && inst_ready) begin
                del_pc.push_back(inst_pc);
                del_inst.push_back(inst);
            end
            w_acc = w_req_valid;
            if (w_req_valid && wlog.size() < 8) wlog.push_back(w_req_addr);
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n || mq_addr.size() == 0) begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end else if (cyc >= mq_cyc[0] + mem_lat - 1) begin
            resp_valid = 1'b1;
            resp_data  = ~mq_addr[0];
        end else begin
            resp_valid = 1'b0;
        end
        w_resp_valid = rst_n && w_acc;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        checks++; if (w_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h want fffffff8", w_req_addr); end
    endtask

    task automatic test_fetch();
        mem_lat = 1; inst_ready = 1'b1;
        do_reset();
        @(negedge clk); #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL fetch_first_req: got %b want 1", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL fetch_first_addr: got %h want 0", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1_valid: got %b want 0", inst_valid); end
        @(negedge clk); #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c2_valid: got %b want 0", inst_valid); end
        checks++; if (req_addr !== 32'h4) begin errors++; $display("FAIL fetch_c2_addr: got %h want 4", req_addr); end
        @(negedge clk); #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_c3_valid: got %b want 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL fetch_c3_pc: got %h want 0", inst_pc); end
        checks++; if (inst !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fetch_c3_inst: got %h want ffffffff", inst); end
        @(negedge clk); #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL fetch_c4_pc: got %b/%h want 1/4", inst_valid, inst_pc); end
        @(negedge clk); #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin errors++; $display("FAIL fetch_c5_pc: got %b/%h want 1/8", inst_valid, inst_pc); end
        repeat (4) @(negedge clk);
        checks++;
        if (acc_log.size() < 6) begin
            errors++; $display("FAIL fetch_req_count: got %0d want >=6", acc_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL fetch_addr_seq[%0d]: got %h want %h", i, acc_log[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        mem_lat = 1; inst_ready = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        #1;
        checks++; if (acc_log.size() !== 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", acc_log.size()); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %b/%h want 1/0", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        n = 0;
        while (del_pc.size() < 8 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (del_pc.size() < 8) begin
            errors++; $display("FAIL bp_resume_timeout: got %0d entries want 8", del_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (del_pc[i] !== 32'(4 * i) || del_inst[i] !== ~32'(4 * i)) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h/%h want %h/%h", i, del_pc[i], del_inst[i], 32'(4 * i), ~32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect_flush();
        int n;
        mem_lat = 3; inst_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_redir_req: got %b want 0", req_valid); end
        checks++; if (acc_log.size() !== 2) begin errors++; $display("FAIL flush_inflight: got %0d want 2", acc_log.size()); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", inst_valid); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_c1_req: got %b want 0", req_valid); end
        @(negedge clk); #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_c2_req: got %b want 0", req_valid); end
        @(negedge clk); #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin errors++; $display("FAIL flush_restart: got %b/%h want 1/100", req_valid, req_addr); end
        n = 0;
        while (del_pc.size() < 2 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (del_pc.size() < 2) begin
            errors++; $display("FAIL flush_deliver_timeout: got %0d entries want 2", del_pc.size());
        end else begin
            checks++; if (del_pc[0] !== 32'h100 || del_inst[0] !== ~32'h100) begin errors++; $display("FAIL flush_first_pc: got %h/%h want 100/%h", del_pc[0], del_inst[0], ~32'h100); end
            checks++; if (del_pc[1] !== 32'h104) begin errors++; $display("FAIL flush_second_pc: got %h want 104", del_pc[1]); end
        end
    endtask

    task automatic test_redirect_coincident();
        int n;
        int stale;
        mem_lat = 1; inst_ready = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        // Response for PC 0xC arrives in this very cycle; head PC 8 is popped.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL coin_req_valid: got %b want 0", req_valid); end
        checks++; if (inst_pc !== 32'h8) begin errors++; $display("FAIL coin_head_pc: got %h want 8", inst_pc); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coin_empty: got %b want 0", inst_valid); end
        checks++; if (del_pc.size() !== 3) begin errors++; $display("FAIL coin_popped: got %0d want 3", del_pc.size()); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin errors++; $display("FAIL coin_restart: got %b/%h want 1/200", req_valid, req_addr); end
        n = 0;
        while (del_pc.size() < 6 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (del_pc.size() < 6) begin
            errors++; $display("FAIL coin_deliver_timeout: got %0d entries want 6", del_pc.size());
        end else begin
            checks++; if (del_pc[3] !== 32'h200) begin errors++; $display("FAIL coin_first_new: got %h want 200", del_pc[3]); end
            checks++; if (del_pc[4] !== 32'h204) begin errors++; $display("FAIL coin_second_new: got %h want 204", del_pc[4]); end
        end
        stale = 0;
        foreach (del_pc[i]) if (del_pc[i] === 32'hC) stale++;
        checks++; if (stale != 0) begin errors++; $display("FAIL coin_stale_pc: got %0d occurrences want 0", stale); end
    endtask

    task automatic test_reset_pc_wrap();
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (wlog.size() < 3) begin
            errors++; $display("FAIL wrap_req_count: got %0d want >=3", wlog.size());
        end else begin
            checks++; if (wlog[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h want fffffff8", wlog[0]); end
            checks++; if (wlog[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1: got %h want fffffffc", wlog[1]); end
            checks++; if (wlog[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr2: got %h want 0", wlog[2]); end
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        mem_lat = 1; inst_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin errors++; $display("FAIL mid_full_head: got %b/%h want 1/300", inst_valid, inst_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %b want 0", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL mid_req_addr: got %h want 0", req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL mid_inst_zero: got %h/%h want 0/0", inst, inst_pc); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; inst_ready = 1'b1;
        n = 0;
        while (del_pc.size() < 2 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (del_pc.size() < 2) begin
            errors++; $display("FAIL mid_restart_timeout: got %0d entries want 2", del_pc.size());
        end else begin
            checks++; if (acc_log[0] !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got %h want 0", acc_log[0]); end
            checks++; if (del_pc[0] !== 32'h0 || del_pc[1] !== 32'h4) begin errors++; $display("FAIL mid_restart_pcs: got %h,%h want 0,4", del_pc[0], del_pc[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_flush();
        test_redirect_coincident();
        test_reset_pc_wrap();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
